// File: rtl/ulpb_trafgen.sv
// ulpb_trafgen: host-side traffic generator/responder for one ULPB node.
// Ports: clk/resetn; START/MODE/DEST_ADDR/NUM_WORDS control, BUSY/DONE/RESULT
// status; TX_* request/ack/response handshake; RX_* auto-ack port with stall;
// TX_WORD_CNT/RX_WORD_CNT saturating counters and RX_CHECKSUM (XOR of RX words).
module ulpb_trafgen #(
  parameter int          ADDR_WIDTH = 8,
  parameter int          DATA_WIDTH = 32,
  parameter int          CNT_WIDTH  = 6,
  parameter logic [31:0] SEED       = 32'hACE12468
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  START,
  input  logic [1:0]            MODE,
  input  logic [ADDR_WIDTH-1:0] DEST_ADDR,
  input  logic [CNT_WIDTH-1:0]  NUM_WORDS,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [1:0]            RESULT,
  output logic [ADDR_WIDTH-1:0] TX_ADDR,
  output logic [DATA_WIDTH-1:0] TX_DATA,
  output logic                  TX_REQ,
  output logic                  TX_PEND,
  input  logic                  TX_ACK,
  input  logic                  TX_SUCC,
  input  logic                  TX_FAIL,
  output logic                  TX_RESP_ACK,
  input  logic                  RX_REQ,
  input  logic [DATA_WIDTH-1:0] RX_DATA,
  output logic                  RX_ACK,
  input  logic                  RX_STALL,
  output logic [CNT_WIDTH-1:0]  TX_WORD_CNT,
  output logic [CNT_WIDTH-1:0]  RX_WORD_CNT,
  output logic [DATA_WIDTH-1:0] RX_CHECKSUM
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_ACK,
    S_WAIT_ACKLO,
    S_WAIT_RESP,
    S_RESP_ACK
  } state_t;

  localparam logic [31:0] POLY = 32'h80200003;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                state;
  state_t                state_nx;
  logic [1:0]            mode_q;
  logic [CNT_WIDTH-1:0]  left_q;
  logic                  more_q;
  logic [31:0]           lfsr_q;
  logic [31:0]           lfsr_nx;
  logic [DATA_WIDTH-1:0] lfsr_word;
  logic                  done_q;
  logic                  start_ok;
  logic                  multi;

  // DONE cycle still counts as busy, so START is only taken after it.
  assign start_ok = START & (state == S_IDLE) & ~done_q;
  assign multi    = (MODE == 2'd1) | (MODE == 2'd2);
  assign lfsr_nx  = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? POLY : 32'h0);

  generate
    if (DATA_WIDTH <= 32) begin : g_narrow
      assign lfsr_word = lfsr_q[DATA_WIDTH-1:0];
    end else begin : g_wide
      assign lfsr_word = {{(DATA_WIDTH-32){1'b0}}, lfsr_q};
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  // TX_FAIL while a word is in flight aborts straight into the
  // response handshake, as if WAIT_RESP had seen the failure.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (start_ok) state_nx = S_LOAD;
      S_LOAD:
        state_nx = TX_FAIL ? S_RESP_ACK : S_WAIT_ACK;
      S_WAIT_ACK:
        if (TX_FAIL)     state_nx = S_RESP_ACK;
        else if (TX_ACK) state_nx = S_WAIT_ACKLO;
      S_WAIT_ACKLO:
        if (TX_FAIL)      state_nx = S_RESP_ACK;
        else if (!TX_ACK) state_nx = more_q ? S_LOAD : S_WAIT_RESP;
      S_WAIT_RESP:
        if (TX_SUCC | TX_FAIL) state_nx = S_RESP_ACK;
      S_RESP_ACK:
        if (!TX_SUCC && !TX_FAIL) state_nx = S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    TX_REQ      = (state == S_WAIT_ACK);
    TX_RESP_ACK = (state == S_RESP_ACK);
    BUSY        = (state != S_IDLE) | done_q;
    DONE        = done_q;
  end

  // left_q holds the words still to send after the current one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mode_q      <= 2'd0;
      left_q      <= '0;
      more_q      <= 1'b0;
      lfsr_q      <= SEED;
      done_q      <= 1'b0;
      RESULT      <= 2'b00;
      TX_ADDR     <= '0;
      TX_DATA     <= '0;
      TX_PEND     <= 1'b0;
      TX_WORD_CNT <= '0;
    end else begin
      done_q <= (state == S_RESP_ACK) & (state_nx == S_IDLE);
      if (start_ok) begin
        mode_q      <= MODE;
        TX_ADDR     <= DEST_ADDR;
        left_q      <= multi ? NUM_WORDS : '0;
        lfsr_q      <= SEED;
        RESULT      <= 2'b00;
        TX_WORD_CNT <= '0;
      end
      if (state == S_LOAD) begin
        TX_DATA <= lfsr_word;
        TX_PEND <= (mode_q == 2'd2) |
                   ((mode_q == 2'd1) & (left_q != '0));
      end
      if (state == S_WAIT_ACK && TX_ACK && !TX_FAIL) begin
        lfsr_q <= lfsr_nx;
        more_q <= (left_q != '0);
        if (left_q != '0)
          left_q <= left_q - 1'b1;
        if (TX_WORD_CNT != CNT_MAX)
          TX_WORD_CNT <= TX_WORD_CNT + 1'b1;
      end
      if (state_nx == S_RESP_ACK && state != S_RESP_ACK)
        RESULT <= TX_FAIL ? 2'b10 : 2'b01;
    end
  end

  // RX auto-ack: a stall only holds off a new ack, never drops one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      RX_ACK      <= 1'b0;
      RX_WORD_CNT <= '0;
      RX_CHECKSUM <= '0;
    end else begin
      if (RX_REQ && !RX_ACK && !RX_STALL) begin
        RX_ACK      <= 1'b1;
        RX_CHECKSUM <= RX_CHECKSUM ^ RX_DATA;
        if (RX_WORD_CNT != CNT_MAX)
          RX_WORD_CNT <= RX_WORD_CNT + 1'b1;
      end else if (RX_ACK && !RX_REQ) begin
        RX_ACK <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ulpb_trafgen.sv
// tb_ulpb_trafgen: randomized node emulation for ulpb_trafgen
// with a word-level reference model and a per-cycle compare process.
module tb_ulpb_trafgen;

  localparam logic [31:0] SEED = 32'hACE12468;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        START = 1'b0;
  logic [1:0]  MODE = '0;
  logic [7:0]  DEST_ADDR = '0;
  logic [5:0]  NUM_WORDS = '0;
  logic        BUSY, DONE;
  logic [1:0]  RESULT;
  logic [7:0]  TX_ADDR;
  logic [31:0] TX_DATA;
  logic        TX_REQ, TX_PEND, TX_RESP_ACK;
  logic        TX_ACK = 1'b0;
  logic        TX_SUCC = 1'b0;
  logic        TX_FAIL = 1'b0;
  logic        RX_REQ = 1'b0;
  logic [31:0] RX_DATA = '0;
  logic        RX_ACK;
  logic        RX_STALL = 1'b0;
  logic [5:0]  TX_WORD_CNT, RX_WORD_CNT;
  logic [31:0] RX_CHECKSUM;

  ulpb_trafgen #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(32),
    .CNT_WIDTH(6),
    .SEED(SEED)
  ) dut (
    .clk(clk), .resetn(resetn),
    .START(START), .MODE(MODE),
    .DEST_ADDR(DEST_ADDR), .NUM_WORDS(NUM_WORDS),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT),
    .TX_ADDR(TX_ADDR), .TX_DATA(TX_DATA),
    .TX_REQ(TX_REQ), .TX_PEND(TX_PEND),
    .TX_ACK(TX_ACK), .TX_SUCC(TX_SUCC),
    .TX_FAIL(TX_FAIL), .TX_RESP_ACK(TX_RESP_ACK),
    .RX_REQ(RX_REQ), .RX_DATA(RX_DATA),
    .RX_ACK(RX_ACK), .RX_STALL(RX_STALL),
    .TX_WORD_CNT(TX_WORD_CNT),
    .RX_WORD_CNT(RX_WORD_CNT),
    .RX_CHECKSUM(RX_CHECKSUM)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  int          rx_exp_cnt = 0;
  logic [31:0] rx_exp_sum = '0;

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Payload of word n of a transaction: SEED stepped n times.
  function automatic logic [31:0] lfsr_n(input int n);
    logic [31:0] v;
    v = SEED;
    for (int i = 0; i < n; i++)
      v = v[0] ? ((v >> 1) ^ 32'h80200003) : (v >> 1);
    return v;
  endfunction

  function automatic int words_for(input logic [1:0] m,
                                   input logic [5:0] n);
    return (m == 2'd1 || m == 2'd2) ? int'(n) + 1 : 1;
  endfunction

  // Compare process: word contents on every TX_REQ cycle, RX ack rules.
  logic [1:0] m_mode = '0;
  logic [7:0] m_dest = '0;
  logic [5:0] m_num = '0;
  int         m_nw = 0;
  int         req_no = 0;
  logic       prev_req = 0;
  logic       prev_rxack = 0;
  logic       prev_rxreq = 0;
  logic       prev_stall = 0;

  always @(negedge clk) begin
    if (!resetn) begin
      prev_req = 0;
      prev_rxack = 0;
    end else begin
      if (START && !BUSY) begin
        m_mode = MODE;
        m_dest = DEST_ADDR;
        m_num  = NUM_WORDS;
        m_nw   = words_for(MODE, NUM_WORDS);
        req_no = 0;
      end
      if (TX_REQ && !prev_req) begin
        req_no++;
        chk("req_in_range", req_no <= m_nw, 1'b1);
      end
      if (TX_REQ) begin
        chk("tx_data", TX_DATA, lfsr_n(req_no - 1));
        chk("tx_addr", TX_ADDR, m_dest);
        chk("tx_pend", TX_PEND,
            (m_mode == 2'd2) ||
            (m_mode == 2'd1 && req_no - 1 < int'(m_num)));
      end
      if (RX_ACK && !prev_rxack)
        chk("rx_rise_cond", {prev_rxreq, prev_stall}, 2'b10);
      prev_req   = TX_REQ;
      prev_rxack = RX_ACK;
    end
    prev_rxreq = RX_REQ;
    prev_stall = RX_STALL;
  end

  task automatic rx_word(input logic [31:0] d, input int stall);
    bit bad;
    RX_DATA = d;
    RX_REQ = 1'b1;
    RX_STALL = (stall > 0);
    if (stall > 0) begin
      bad = 0;
      repeat (stall) begin
        tick();
        if (RX_ACK) bad = 1;
      end
      chk("rx_stall_delay", bad, 1'b0);
      RX_STALL = 1'b0;
    end
    tick();
    chk("rx_ack_rise", RX_ACK, 1'b1);
    if (rx_exp_cnt < 63) rx_exp_cnt++;
    rx_exp_sum ^= d;
    chk("rx_word_cnt", RX_WORD_CNT, rx_exp_cnt);
    chk("rx_checksum", RX_CHECKSUM, rx_exp_sum);
    RX_STALL = 1'($urandom_range(0, 1));
    tick();
    chk("rx_ack_hold", RX_ACK, 1'b1);
    RX_REQ = 1'b0;
    RX_STALL = 1'b0;
    tick();
    chk("rx_ack_fall", RX_ACK, 1'b0);
  endtask

  task automatic txn(input logic [1:0] mode, input logic [7:0] dest,
                     input logic [5:0] num, input int abort_at,
                     input bit resp_fail, input int poke_at,
                     input int rst_at);
    int nw;
    int hand;
    bit aborted;
    bit bad;
    nw = words_for(mode, num);
    hand = 0;
    aborted = 0;
    MODE = mode;
    DEST_ADDR = dest;
    NUM_WORDS = num;
    START = 1'b1;
    tick();
    START = 1'b0;
    MODE = 2'($urandom);
    DEST_ADDR = 8'($urandom);
    NUM_WORDS = 6'($urandom);
    chk("busy_after_start", BUSY, 1'b1);
    chk("req_lat_1", TX_REQ, 1'b0);
    tick();
    chk("req_lat_2", TX_REQ, 1'b1);
    for (int w = 0; w < nw; w++) begin
      if (w == 0) chk("word0_seed", TX_DATA, 32'hACE12468);
      if (w == 1) chk("word1", TX_DATA, 32'h56709234);
      if (w == nw - 1 && mode == 2'd1)
        chk("last_pend", TX_PEND, 1'b0);
      if (mode == 2'd2) chk("uf_pend", TX_PEND, 1'b1);
      if (w == rst_at) begin
        resetn = 1'b0;
        #1;
        chk("reset_clear",
            {BUSY, DONE, RESULT, TX_ADDR, TX_DATA, TX_REQ, TX_PEND,
             TX_RESP_ACK, RX_ACK, TX_WORD_CNT, RX_WORD_CNT,
             RX_CHECKSUM}, 0);
        TX_ACK = 1'b0;
        rx_exp_cnt = 0;
        rx_exp_sum = '0;
        tick();
        tick();
        resetn = 1'b1;
        bad = 0;
        repeat (3) begin
          tick();
          if (DONE || BUSY || TX_REQ) bad = 1;
        end
        chk("no_done_after_reset", bad, 1'b0);
        return;
      end
      if (w == abort_at) begin
        aborted = 1;
        TX_FAIL = 1'b1;
        tick();
        chk("abort_req_low", TX_REQ, 1'b0);
        chk("abort_resp_ack", TX_RESP_ACK, 1'b1);
        TX_FAIL = 1'b0;
        break;
      end
      if (w == poke_at) begin
        START = 1'b1;
        DEST_ADDR = ~dest;
        MODE = 2'd0;
        tick();
        START = 1'b0;
      end
      repeat ($urandom_range(0, 3)) tick();
      chk("req_held", TX_REQ, 1'b1);
      TX_ACK = 1'b1;
      tick();
      chk("req_fall", TX_REQ, 1'b0);
      hand++;
      repeat ($urandom_range(0, 2)) tick();
      TX_ACK = 1'b0;
      if (w < nw - 1) begin
        tick();
        chk("req_gap", TX_REQ, 1'b0);
        tick();
        chk("req_rearm", TX_REQ, 1'b1);
      end
    end
    if (!aborted) begin
      bad = 0;
      repeat (4) begin
        tick();
        if (TX_REQ) bad = 1;
      end
      chk("no_extra_req", bad, 1'b0);
      if (resp_fail) TX_FAIL = 1'b1;
      else TX_SUCC = 1'b1;
      tick();
      chk("resp_ack_rise", TX_RESP_ACK, 1'b1);
      repeat ($urandom_range(0, 2)) tick();
      chk("resp_ack_held", TX_RESP_ACK, 1'b1);
      TX_SUCC = 1'b0;
      TX_FAIL = 1'b0;
    end
    tick();
    chk("done_pulse", DONE, 1'b1);
    chk("resp_ack_fall", TX_RESP_ACK, 1'b0);
    chk("result", RESULT,
        (aborted || resp_fail) ? 2'b10 : 2'b01);
    chk("tx_word_cnt", TX_WORD_CNT, hand > 63 ? 63 : hand);
    tick();
    chk("done_one_cycle", DONE, 1'b0);
    chk("idle_busy", BUSY, 1'b0);
    bad = 0;
    repeat (2) begin
      tick();
      if (TX_REQ) bad = 1;
    end
    chk("quiet_after_done", bad, 1'b0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state",
        {BUSY, DONE, RESULT, TX_ADDR, TX_DATA, TX_REQ, TX_PEND,
         TX_RESP_ACK, RX_ACK, TX_WORD_CNT, RX_WORD_CNT,
         RX_CHECKSUM}, 0);
    resetn = 1'b1;
    tick();

    rx_word(32'h1, 0);
    rx_word(32'h2, 10);
    rx_word(32'h4, 0);
    chk("rx_dir_cnt", RX_WORD_CNT, 6'd3);
    chk("rx_dir_sum", RX_CHECKSUM, 32'h7);

    txn(2'd0, 8'hcd, 6'd5, -1, 0, -1, -1);
    txn(2'd1, 8'h3a, 6'd7, -1, 0, -1, -1);
    txn(2'd2, 8'h51, 6'd7, -1, 1, -1, -1);
    txn(2'd1, 8'h77, 6'd7, 2, 0, -1, -1);
    txn(2'd3, 8'h12, 6'd9, -1, 0, -1, -1);
    txn(2'd1, 8'hee, 6'd0, -1, 0, -1, -1);
    txn(2'd1, 8'h99, 6'd63, -1, 0, -1, -1);
    txn(2'd1, 8'h42, 6'd4, -1, 0, 1, -1);

    for (int it = 0; it < 12; it++) begin
      logic [1:0] m;
      logic [5:0] n;
      int nw, ab, pk;
      m  = 2'($urandom_range(0, 3));
      n  = 6'($urandom_range(0, 9));
      nw = words_for(m, n);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nw - 1)) : -1;
      pk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nw - 1)) : -1;
      fork
        txn(m, 8'($urandom), n, ab, 1'($urandom_range(0, 1)), pk, -1);
        repeat ($urandom_range(1, 6))
          rx_word($urandom, int'($urandom_range(0, 3)));
      join
    end

    txn(2'd1, 8'hb4, 6'd7, -1, 0, -1, 3);
    txn(2'd0, 8'h0f, 6'd0, -1, 0, -1, -1);

    repeat (70) rx_word($urandom, 0);
    chk("rx_cnt_sat", RX_WORD_CNT, 6'd63);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
